// File: rtl/aes_sbox_pkg.sv
// Shared constants, FSM state type and GF(2^8) helpers for the sbox scheduler.
package aes_sbox_pkg;

    localparam int         NUM_LANES        = 20;
    localparam int         SB_LANES         = 16;
    localparam int         KS_LANE_BASE     = 16;
    localparam logic [7:0] SBOX_ZERO_RESULT = 8'h63;
    localparam logic [7:0] GEN              = 8'h03;
    localparam logic [7:0] GEN_INV          = 8'hf6;

    typedef enum logic [1:0] {IDLE, WALK, RSP} state_e;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = xtime(x);
        end
        return acc;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
        logic [15:0] w;
        w = {a, a} << n;
        return w[15:8];
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] inv);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

endpackage

// File: rtl/sbox_sched_sbox.sv
// Iterative multi-lane sbox: walks g^t and g^-t in lockstep; a lane whose index equals g^t
// takes g^-t as its inverse. Deasserting en restarts the walk.
module sbox_sched_sbox
    import aes_sbox_pkg::*;
(
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           en,
    input  logic [NUM_LANES-1:0][7:0]      idx,
    output logic                           done,
    output logic [NUM_LANES-1:0][7:0]      sbout
);

    logic [7:0]                 pow_q, pow_d;
    logic [7:0]                 inv_q, inv_d;
    logic [NUM_LANES-1:0]       hit_q, hit_d;
    logic [NUM_LANES-1:0][7:0]  res_q, res_d;
    logic [NUM_LANES-1:0]       lane_hit;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        // Zero has no inverse; it completes at once with the fixed affine image.
        assign lane_hit[g] = hit_q[g] | (idx[g] == 8'h00) | (idx[g] == pow_q);
        assign sbout[g]    = hit_q[g]          ? res_q[g]         :
                             (idx[g] == 8'h00) ? SBOX_ZERO_RESULT : affine(inv_q);
    end

    assign done = en & (&lane_hit);

    always_comb begin
        pow_d = 8'h01;
        inv_d = 8'h01;
        hit_d = '0;
        res_d = res_q;
        if (en) begin
            pow_d = gf_mul(pow_q, GEN);
            inv_d = gf_mul(inv_q, GEN_INV);
            hit_d = lane_hit;
            res_d = sbout;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pow_q <= 8'h01;
            inv_q <= 8'h01;
            hit_q <= '0;
            res_q <= '0;
        end else begin
            pow_q <= pow_d;
            inv_q <= inv_d;
            hit_q <= hit_d;
            res_q <= res_d;
        end
    end

endmodule

// File: rtl/sbox_sched.sv
// Shares one iterative sbox between SubBytes (lanes 0-15) and SubWord (lanes 16-19).
// Optional walk timeout with sticky err: define SBOX_SCHED_TIMEOUT_EN.
module sbox_sched
    import aes_sbox_pkg::*;
#(
    parameter int WALK_MAX = 256,
    parameter int CNT_W    = 9
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          sb_req_valid,
    output logic          sb_req_ready,
    input  logic [127:0]  sb_req_data,
    output logic          sb_rsp_valid,
    input  logic          sb_rsp_ready,
    output logic [127:0]  sb_rsp_data,
    input  logic          ks_req_valid,
    output logic          ks_req_ready,
    input  logic [31:0]   ks_req_data,
    output logic          ks_rsp_valid,
    input  logic          ks_rsp_ready,
    output logic [31:0]   ks_rsp_data,
    output logic          busy,
    output logic          err
);

    if (CNT_W < $clog2(WALK_MAX + 1)) begin : g_cnt_w_chk
        $error("CNT_W too narrow to hold WALK_MAX");
    end

    state_e                     state_q, state_d;
    logic                       sb_acc_q, sb_acc_d, ks_acc_q, ks_acc_d;
    logic                       sb_vld_q, sb_vld_d, ks_vld_q, ks_vld_d;
    logic [NUM_LANES-1:0][7:0]  lanes_q, lanes_d;
    logic [127:0]               sb_res_q, sb_res_d;
    logic [31:0]                ks_res_q, ks_res_d;
    logic                       sbox_en;
    logic                       sbox_done;
    logic [NUM_LANES-1:0][7:0]  sbox_out;
`ifdef SBOX_SCHED_TIMEOUT_EN
    logic                       err_q, err_d;
    logic [CNT_W-1:0]           walk_cnt_q, walk_cnt_d;
`endif

    sbox_sched_sbox u_sbox (
        .clk    (clk),
        .resetn (resetn),
        .en     (sbox_en),
        .idx    (lanes_q),
        .done   (sbox_done),
        .sbout  (sbox_out)
    );

    always_comb begin
        state_d      = state_q;
        sb_acc_d     = sb_acc_q;
        ks_acc_d     = ks_acc_q;
        sb_vld_d     = sb_vld_q;
        ks_vld_d     = ks_vld_q;
        lanes_d      = lanes_q;
        sb_res_d     = sb_res_q;
        ks_res_d     = ks_res_q;
        sb_req_ready = 1'b0;
        ks_req_ready = 1'b0;
        sbox_en      = 1'b0;
`ifdef SBOX_SCHED_TIMEOUT_EN
        err_d        = err_q;
        walk_cnt_d   = walk_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                sb_req_ready = 1'b1;
                ks_req_ready = 1'b1;
                if (sb_req_valid || ks_req_valid) begin
                    sb_acc_d = sb_req_valid;
                    ks_acc_d = ks_req_valid;
                    // Idle lanes carry 0x00 so they never hold up done.
                    lanes_d  = '0;
                    if (sb_req_valid) lanes_d[SB_LANES-1:0] = sb_req_data;
                    if (ks_req_valid) lanes_d[NUM_LANES-1:KS_LANE_BASE] = ks_req_data;
`ifdef SBOX_SCHED_TIMEOUT_EN
                    walk_cnt_d = '0;
`endif
                    state_d  = WALK;
                end
            end
            WALK: begin
                sbox_en = 1'b1;
                if (sbox_done) begin
                    if (sb_acc_q) sb_res_d = sbox_out[SB_LANES-1:0];
                    if (ks_acc_q) ks_res_d = sbox_out[NUM_LANES-1:KS_LANE_BASE];
                    sb_vld_d = sb_acc_q;
                    ks_vld_d = ks_acc_q;
                    state_d  = RSP;
                end
`ifdef SBOX_SCHED_TIMEOUT_EN
                else if (walk_cnt_q == CNT_W'(WALK_MAX - 1)) begin
                    err_d    = 1'b1;
                    if (sb_acc_q) sb_res_d = '0;
                    if (ks_acc_q) ks_res_d = '0;
                    sb_vld_d = sb_acc_q;
                    ks_vld_d = ks_acc_q;
                    state_d  = RSP;
                end else begin
                    walk_cnt_d = walk_cnt_q + 1'b1;
                end
`endif
            end
            RSP: begin
                if (sb_rsp_ready) sb_vld_d = 1'b0;
                if (ks_rsp_ready) ks_vld_d = 1'b0;
                if (!sb_vld_d && !ks_vld_d) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            sb_acc_q <= 1'b0;
            ks_acc_q <= 1'b0;
            sb_vld_q <= 1'b0;
            ks_vld_q <= 1'b0;
            lanes_q  <= '0;
            sb_res_q <= '0;
            ks_res_q <= '0;
        end else begin
            state_q  <= state_d;
            sb_acc_q <= sb_acc_d;
            ks_acc_q <= ks_acc_d;
            sb_vld_q <= sb_vld_d;
            ks_vld_q <= ks_vld_d;
            lanes_q  <= lanes_d;
            sb_res_q <= sb_res_d;
            ks_res_q <= ks_res_d;
        end
    end

`ifdef SBOX_SCHED_TIMEOUT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_q      <= 1'b0;
            walk_cnt_q <= '0;
        end else begin
            err_q      <= err_d;
            walk_cnt_q <= walk_cnt_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign sb_rsp_valid = sb_vld_q;
    assign ks_rsp_valid = ks_vld_q;
    assign sb_rsp_data  = sb_res_q;
    assign ks_rsp_data  = ks_res_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_sbox_sched.sv
// Directed bench for sbox_sched: latency, merging, backpressure, async reset, optional timeout.
module tb_sbox_sched;

`ifdef SBOX_SCHED_TIMEOUT_EN
    localparam int WALK_MAX = 8;
`else
    localparam int WALK_MAX = 256;
`endif

    logic         clk = 1'b0;
    logic         resetn;
    logic         sb_req_valid, sb_req_ready, sb_rsp_valid, sb_rsp_ready;
    logic [127:0] sb_req_data, sb_rsp_data;
    logic         ks_req_valid, ks_req_ready, ks_rsp_valid, ks_rsp_ready;
    logic [31:0]  ks_req_data, ks_rsp_data;
    logic         busy, err;

    int n_chk = 0;
    int n_err = 0;

    sbox_sched #(.WALK_MAX(WALK_MAX), .CNT_W(9)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .sb_req_valid (sb_req_valid),
        .sb_req_ready (sb_req_ready),
        .sb_req_data  (sb_req_data),
        .sb_rsp_valid (sb_rsp_valid),
        .sb_rsp_ready (sb_rsp_ready),
        .sb_rsp_data  (sb_rsp_data),
        .ks_req_valid (ks_req_valid),
        .ks_req_ready (ks_req_ready),
        .ks_req_data  (ks_req_data),
        .ks_rsp_valid (ks_rsp_valid),
        .ks_rsp_ready (ks_rsp_ready),
        .ks_rsp_data  (ks_rsp_data),
        .busy         (busy),
        .err          (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Discrete log base 0x03 by repeated multiplication.
    function automatic int glog(input logic [7:0] b);
        logic [7:0] p;
        p = 8'h01;
        for (int t = 0; t < 255; t++) begin
            if (p == b) return t;
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
        end
        return -1;
    endfunction

    task automatic issue(input logic sbv, input logic [127:0] sbd,
                         input logic ksv, input logic [31:0] ksd);
        @(negedge clk);
        chk("req_ready_idle", {sb_req_ready, ks_req_ready}, 2'b11);
        sb_req_valid = sbv;
        sb_req_data  = sbd;
        ks_req_valid = ksv;
        ks_req_data  = ksd;
        @(posedge clk);
        #1;
        sb_req_valid = 1'b0;
        ks_req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!(sb_rsp_valid || ks_rsp_valid) && lat < 400) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("rsp_timeout", lat < 400, 1'b1);
    endtask

    task automatic drain();
        sb_rsp_ready = 1'b1;
        ks_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        sb_rsp_ready = 1'b0;
        ks_rsp_ready = 1'b0;
        chk("idle_after_drain", busy, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, nrsp, min_gap, gap, bad_rdy, bad_hold;
        logic seen_en;
        logic [127:0] rsp [2];

        resetn = 1'b0;
        sb_req_valid = 1'b0; sb_req_data = '0; sb_rsp_ready = 1'b0;
        ks_req_valid = 1'b0; ks_req_data = '0; ks_rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_rsp_valid", {sb_rsp_valid, ks_rsp_valid}, 2'b00);
        chk("rst_sb_data", sb_rsp_data, '0);
        chk("rst_ks_data", ks_rsp_data, '0);
        chk("rst_en", dut.sbox_en, 1'b0);
        @(negedge clk);
        resetn = 1'b1;

        // SubBytes only, all zero bytes.
        issue(1'b1, '0, 1'b0, 32'h0);
        wait_rsp(lat);
        chk("sb0_lat", lat, 1);
        chk("sb0_valid", {sb_rsp_valid, ks_rsp_valid}, 2'b10);
        chk("sb0_data", sb_rsp_data, {16{8'h63}});
        chk("sb0_busy", busy, 1'b1);
        drain();

`ifndef SBOX_SCHED_TIMEOUT_EN
        // SubWord only.
        issue(1'b0, '0, 1'b1, 32'h00_01_03_53);
        wait_rsp(lat);
        chk("ks_lat", lat, 1 + glog(8'h53));
        chk("ks_valid", {sb_rsp_valid, ks_rsp_valid}, 2'b01);
        chk("ks_data", ks_rsp_data, 32'h63_7c_7b_ed);
        drain();

        // Merged batch with the slowest byte.
        issue(1'b1, 128'hf6, 1'b1, 32'h00_01_03_53);
        wait_rsp(lat);
        chk("both_lat", lat, 255);
        chk("both_valid", {sb_rsp_valid, ks_rsp_valid}, 2'b11);
        chk("both_sb_data", sb_rsp_data, {{15{8'h63}}, 8'h42});
        chk("both_ks_data", ks_rsp_data, 32'h63_7c_7b_ed);
        drain();
`endif

        // Back-to-back: request held high across a whole batch.
        @(negedge clk);
        sb_req_valid = 1'b1;
        sb_req_data  = 128'h03;
        sb_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        sb_req_data = {16{8'h01}};
        nrsp = 0; min_gap = 1000; gap = 0; seen_en = 1'b0; bad_rdy = 0;
        for (int c = 0; c < 20; c++) begin
            if (dut.sbox_en) begin
                if (seen_en && gap > 0 && gap < min_gap) min_gap = gap;
                seen_en = 1'b1;
                gap = 0;
            end else begin
                gap++;
            end
            if (busy && sb_req_ready) bad_rdy++;
            if (sb_rsp_valid && nrsp < 2) begin
                rsp[nrsp] = sb_rsp_data;
                nrsp++;
                if (nrsp == 2) sb_req_valid = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        sb_req_valid = 1'b0;
        sb_rsp_ready = 1'b0;
        chk("b2b_nrsp", nrsp, 2);
        chk("b2b_rsp0", rsp[0], {{15{8'h63}}, 8'h7b});
        chk("b2b_rsp1", rsp[1], {16{8'h7c}});
        chk("b2b_en_gap", (min_gap >= 2) && (min_gap < 1000), 1'b1);
        chk("b2b_ready_busy", bad_rdy, 0);
        chk("b2b_idle", busy, 1'b0);

        // Backpressure on SubBytes with a SubWord request waiting.
        issue(1'b1, {8'h03, {15{8'h01}}}, 1'b0, 32'h0);
        wait_rsp(lat);
        chk("bp_lat", lat, 2);
        ks_req_valid = 1'b1;
        ks_req_data  = 32'h0;
        ks_rsp_ready = 1'b1;
        bad_hold = 0;
        for (int c = 0; c < 10; c++) begin
            if (!sb_rsp_valid || sb_rsp_data !== {8'h7b, {15{8'h7c}}} ||
                ks_req_ready || sb_req_ready || ks_rsp_valid) bad_hold++;
            @(posedge clk);
            #1;
        end
        chk("bp_hold", bad_hold, 0);
        sb_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        sb_rsp_ready = 1'b0;
        chk("bp_drained", {busy, sb_rsp_valid}, 2'b00);
        @(posedge clk);
        #1;
        ks_req_valid = 1'b0;
        chk("bp_ks_accept", busy, 1'b1);
        wait_rsp(lat);
        chk("bp_ks_valid", {sb_rsp_valid, ks_rsp_valid}, 2'b01);
        chk("bp_ks_data", ks_rsp_data, {4{8'h63}});
        drain();

        // Asynchronous reset mid-walk, then a fresh request.
        issue(1'b1, 128'hf6, 1'b0, 32'h0);
        repeat (4) @(posedge clk);
        #1;
        chk("mid_busy", busy, 1'b1);
        resetn = 1'b0;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_en", dut.sbox_en, 1'b0);
        chk("arst_valid", {sb_rsp_valid, ks_rsp_valid}, 2'b00);
        chk("arst_sb_data", sb_rsp_data, '0);
        chk("arst_ready", {sb_req_ready, ks_req_ready}, 2'b11);
        @(negedge clk);
        resetn = 1'b1;
        issue(1'b0, '0, 1'b1, 32'h00_05_03_01);
        wait_rsp(lat);
        chk("post_rst_lat", lat, 3);
        chk("post_rst_data", ks_rsp_data, 32'h63_6b_7b_7c);
        drain();

`ifdef SBOX_SCHED_TIMEOUT_EN
        issue(1'b1, 128'hf6, 1'b0, 32'h0);
        wait_rsp(lat);
        chk("to_lat", lat, WALK_MAX);
        chk("to_err", err, 1'b1);
        chk("to_sb_data", sb_rsp_data, '0);
        drain();
        chk("to_err_sticky", err, 1'b1);
`else
        chk("err_tied", err, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
